project_8: RTL and testbench

- Registered WIDTH-bit Kogge-Stone parallel-prefix adder: Sum = A + B + Cin, with carry-out.
- Carries come from a log2(WIDTH)-level prefix network, so the critical path is O(log WIDTH).
- Result is registered once, giving one cycle of latency.
- Used as a fast datapath adder wherever a single-cycle, registered add is needed.

---
 rtl/project_8_if.sv | 34 +++
 rtl/project_8.sv | 78 +++++++
 tb/tb_project_8.sv | 119 +++++++++++
 3 files changed

// File: rtl/project_8_if.sv
// Operand/result bundle for the registered Kogge-Stone adder.
// PROJECT8_OVF_EN adds the registered signed-overflow flag Ovf.
interface project_8_if #(
  parameter int WIDTH = 16
);
  // Operands are taken on any rising edge where in_valid=1; there is no ready,
  // so the adder accepts every cycle. out_valid=1 marks a fresh Sum/Cout.
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef PROJECT8_OVF_EN
  logic             Ovf;
`endif

  modport master (
    output in_valid, A, B, Cin,
`ifdef PROJECT8_OVF_EN
    input  Ovf,
`endif
    input  out_valid, Sum, Cout
  );

  modport slave (
    input  in_valid, A, B, Cin,
`ifdef PROJECT8_OVF_EN
    output Ovf,
`endif
    output out_valid, Sum, Cout
  );
endinterface

// File: rtl/project_8.sv
// Registered WIDTH-bit Kogge-Stone adder: {Cout,Sum} = A + B + Cin, one cycle latency.
// PROJECT8_OVF_EN adds the registered two's-complement overflow output Ovf.
module project_8 #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  project_8_if.slave   bus
);
  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] gl [0:LEVELS];
  logic [WIDTH-1:0] pl [0:LEVELS];
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_next;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             valid_q;

  // Every bit gets a black cell at every level where i >= span, so after
  // LEVELS levels gl/pl hold the group generate/propagate over [i:0].
  always_comb begin
    for (int k = 0; k <= LEVELS; k++) begin
      gl[k] = '0;
      pl[k] = '0;
    end
    gl[0] = bus.A & bus.B;
    pl[0] = bus.A ^ bus.B;
    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) begin
          gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i-(1 << k)]);
          pl[k+1][i] = pl[k][i] & pl[k][i-(1 << k)];
        end else begin
          gl[k+1][i] = gl[k][i];
          pl[k+1][i] = pl[k][i];
        end
      end
    end
  end

  assign c[0]       = bus.Cin;
  assign c[WIDTH:1] = gl[LEVELS] | (pl[LEVELS] & {WIDTH{bus.Cin}});
  assign sum_next   = pl[0] ^ c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q  <= sum_next;
        cout_q <= c[WIDTH];
      end
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.out_valid = valid_q;

`ifdef PROJECT8_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

  assign bus.Ovf = ovf_q;
`endif
endmodule

// File: tb/tb_project_8.sv
// Directed and random checks of project_8 (WIDTH=16) at one-cycle latency.
module tb_project_8;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  project_8_if #(.WIDTH(WIDTH)) bus ();

  project_8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample 1 time unit later.
  task automatic step(input logic rst, input logic vld, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic cin);
    rst_n        = rst;
    bus.in_valid = vld;
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [WIDTH-1:0] sum,
                            input logic cout, input logic ovf);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    check({tag, ".Sum"}, 32'(bus.Sum), 32'(sum));
    check({tag, ".Cout"}, 32'(bus.Cout), 32'(cout));
`ifdef PROJECT8_OVF_EN
    check({tag, ".Ovf"}, 32'(bus.Ovf), 32'(ovf));
`else
    if (ovf === 1'bx) $display("unexpected X in expected ovf for %s", tag);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic [WIDTH:0]   ref_full;
    logic             ref_ovf;

    n_checks = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.Cin      = 1'b0;
    #1;

    // Reset with live operands must still clear everything.
    step(1'b0, 1'b1, 16'(($urandom_range(0, 65535))), 16'(($urandom_range(0, 65535))), 1'b1);
    expect_out("reset0", 1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'(($urandom_range(0, 65535))), 16'(($urandom_range(0, 65535))), 1'b1);
    expect_out("reset1", 1'b0, 16'h0000, 1'b0, 1'b0);

    step(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
    expect_out("basic", 1'b1, 16'h68AC, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
    expect_out("ripple_aaaa", 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    expect_out("ripple_ffff", 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_out("max_ffff", 1'b1, 16'hFFFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
    expect_out("neg_ovf", 1'b1, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    expect_out("pos_ovf", 1'b1, 16'h8000, 1'b0, 1'b1);

    // Streaming then idle: results on consecutive cycles, then held.
    step(1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0);
    expect_out("stream0", 1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0010, 16'h0020, 1'b1);
    expect_out("stream1", 1'b1, 16'h0031, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 16'h0002, 1'b0);
    expect_out("stream2", 1'b1, 16'h0001, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b1);
    expect_out("idle0", 1'b0, 16'h0001, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h4444, 16'h8888, 1'b0);
    expect_out("idle1", 1'b0, 16'h0001, 1'b1, 1'b0);

    // Mid-stream reset discards the operands presented on that edge.
    step(1'b1, 1'b1, 16'h1111, 16'h1111, 1'b0);
    expect_out("pre_rst", 1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_out("mid_rst", 1'b0, 16'h0000, 1'b0, 1'b0);

    for (int n = 0; n < 10000; n++) begin
      ra       = 16'($urandom_range(0, 65535));
      rb       = 16'($urandom_range(0, 65535));
      rc       = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      ref_ovf  = (ra[WIDTH-1] == rb[WIDTH-1]) && (ref_full[WIDTH-1] != ra[WIDTH-1]);
      step(1'b1, 1'b1, ra, rb, rc);
      expect_out("random", 1'b1, ref_full[WIDTH-1:0], ref_full[WIDTH], ref_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
